// File: rtl/mdu_ctrl.sv
// HI/LO sequencer for the E-stage multiply/divide unit with fixed per-op latency.
// Define MDU_MADD_EN to add the madd/maddu/msub/msubu accumulate ops (codes 6..9).
module mdu_ctrl #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi_pend;
  logic [31:0] lo_pend;

  logic [63:0] prod_s, prod_u;
  logic        div_sgn;
  logic [31:0] a_mag, b_mag, dvd, dvs, q_mag, r_mag, quo, rem;
  logic        long_op;
  logic [3:0]  lat;
  logic [63:0] res;

  assign state_dbg = (state == RUN);

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign div_sgn = (op == 4'd2);
  assign a_mag   = a[31] ? 32'd0 - a : a;
  assign b_mag   = b[31] ? 32'd0 - b : b;
  assign dvd     = div_sgn ? a_mag : a;
  assign dvs     = div_sgn ? b_mag : b;
  assign q_mag   = dvd / dvs;
  assign r_mag   = dvd % dvs;
  assign quo     = (div_sgn && (a[31] ^ b[31])) ? 32'd0 - q_mag : q_mag;
  assign rem     = (div_sgn && a[31]) ? 32'd0 - r_mag : r_mag;

  always_comb begin
    long_op = 1'b0;
    lat     = MUL_CYCLES[3:0];
    res     = {hi, lo};
    case (op)
      4'd0: begin long_op = 1'b1; res = prod_s; end
      4'd1: begin long_op = 1'b1; res = prod_u; end
      4'd2, 4'd3: begin
        long_op = 1'b1;
        lat     = DIV_CYCLES[3:0];
        res     = (b == 32'd0) ? {hi, lo} : {rem, quo};
      end
`ifdef MDU_MADD_EN
      4'd6: begin long_op = 1'b1; res = {hi, lo} + prod_s; end
      4'd7: begin long_op = 1'b1; res = {hi, lo} + prod_u; end
      4'd8: begin long_op = 1'b1; res = {hi, lo} - prod_s; end
      4'd9: begin long_op = 1'b1; res = {hi, lo} - prod_u; end
`endif
      default: ;
    endcase
  end

  // Handshake: an op is taken on an edge where start & !cancel and busy is low;
  // start while busy is dropped, and done pulses once when the result lands in HI/LO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            if (long_op) begin
              hi_pend <= res[63:32];
              lo_pend <= res[31:0];
              cnt     <= lat;
              state   <= RUN;
              busy    <= 1'b1;
            end else if (op == 4'd4) begin
              hi <= a;
            end else if (op == 4'd5) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (cnt == 4'd1) begin
            hi    <= hi_pend;
            lo    <= lo_pend;
            cnt   <= 4'd0;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit controller for the 5-stage MIPS pipeline. It sits in the E stage and sequences HI/LO-writing operations: mult, multu, div, divu, mthi and mtlo. It models fixed multi-cycle latency with an internal counter and drives the busy signal that the hazard unit uses to stall D-stage mul/div instructions. It also suppresses operation start when an interrupt/exception request cancels the E-stage instruction.

Parameters:
MUL_CYCLES, 5, busy duration for mult/multu (and madd-family when enabled); legal range 1..15
DIV_CYCLES, 10, busy duration for div/divu; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
start  input  1  E-stage instruction is an MDU op this cycle
op  input  4  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu, 8 msub, 9 msubu, others no-op
a  input  32  forwarded rs operand
b  input  32  forwarded rt operand
cancel  input  1  IntReq; kills this cycle's start
busy  output  1  high while a mult/div is in flight
hi  output  32  architectural HI
lo  output  32  architectural LO
done  output  1  one-cycle pulse: new HI/LO visible

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE, cnt=0, busy=0, done=0, hi=lo=0, pending registers=0. Reset mid-operation aborts the operation; no commit.
- States: IDLE, RUN. busy = (state==RUN), registered.
- Accept condition: start & !cancel & state==IDLE. start during RUN is ignored, including mthi/mtlo. The hazard unit guarantees this does not happen; the bench checks that it is ignored.
- mult/multu/div/divu accepted at edge k:
  - hi_pend/lo_pend computed from a, b and latched; cnt loaded with MUL_CYCLES or DIV_CYCLES; state becomes RUN.
  - busy is high for cycles k+1 .. k+N (N = latency).
  - At edge k+N: hi<=hi_pend, lo<=lo_pend, state becomes IDLE, done=1 for cycle k+N+1 only.
  - hi/lo keep their old values throughout RUN.
- mthi/mtlo accepted: hi<=a (or lo<=a) at the same edge; no busy; done stays 0.
- Arithmetic:
  - mult: signed 64-bit product {hi,lo}. multu: unsigned product.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. divu: unsigned quotient and remainder.
  - Overflow case: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Divide by zero (b==0): still runs DIV_CYCLES busy; pending = current hi/lo, so HI/LO are unchanged; done still pulses.
- cancel=1 with start=1: no state change, no HI/LO write, busy stays 0.
  - cancel does not affect an operation already in RUN; it continues and commits.
- done and accept in the same cycle: a new op may be accepted in the cycle after busy falls (state IDLE). Back-to-back ops therefore give busy 0 for exactly one cycle between them.
- Unused op codes with start=1: no-op.

Optional Feature:
MDU_MADD_EN:
- Defined: ops 6..9 are accepted with MUL_CYCLES latency.
  - madd: {hi,lo} + signed a*b. maddu: unsigned.
  - msub: {hi,lo} - signed a*b. msubu: unsigned.
  - All use 64-bit wrap-around.
  - The accumulator base is the hi/lo value at the accept edge.
- Undefined: ops 6..9 are treated as unused no-op codes; no accumulate logic is synthesised.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3, start at cycle 0 -> busy=1 for cycles 1..5; hi=0xFFFFFFFF, lo=0xFFFFFFFA visible at cycle 6 with done=1; hi/lo=0 during cycles 1..5.
- div a=0xFFFFFFF9 (-7), b=2 -> busy for cycles 1..10; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=0 -> busy for 10 cycles; hi/lo unchanged; done pulses.
- mthi a=0x12345678 -> hi=0x12345678 the next cycle, busy stays 0. mtlo issued while busy -> ignored; lo keeps its committed value.
- start=1, cancel=1, op=mult -> busy stays 0, hi/lo unchanged. cancel=1 asserted at cycle 3 of an in-flight mult -> result still commits at cycle 6.
- reset_n=0 at cycle 4 of a div -> next cycle busy=0, hi=lo=0, no done pulse afterwards.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu a=1, b=1 -> hi=1, lo=0 after 5 busy cycles. Without MDU_MADD_EN: op=6 -> no busy, no change.
